// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 8;
  localparam int DEF_REPEAT_PERIOD   = 4;
  localparam int PRESS_COUNT_W       = 8;

  // Width of a counter that must hold 0..max_val-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw button level; 2-cycle latency, no backpressure.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces a push button into a level, press/release/repeat pulses and a press count.
// Press accepted on the (DEBOUNCE_CYCLES+3)th edge of stable high; no backpressure. Auto-repeat needs BTN_AUTO_REPEAT_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_in,
  output logic                     btn_level,
  output logic                     press_pulse,
  output logic                     release_pulse,
  output logic                     repeat_pulse,
  output logic [PRESS_COUNT_W-1:0] press_count
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_conditioner: parameter out of legal range");
  end

  logic            sync_level;
  btn_state_t      state;
  btn_state_t      state_nxt;
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_cnt_nxt;
  logic            press_evt;
  logic            release_evt;

  btn_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_in),
    .dout (sync_level)
  );

  always_comb begin
    state_nxt   = state;
    db_cnt_nxt  = db_cnt;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state)
      IDLE: begin
        if (sync_level) begin
          state_nxt  = PRESS_WAIT;
          db_cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_level) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = '0;
          press_evt  = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!sync_level) begin
          state_nxt  = RELEASE_WAIT;
          db_cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        // A short low blip while held is a glitch: return without re-announcing the press.
        if (sync_level) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt   = IDLE;
          db_cnt_nxt  = '0;
          release_evt = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        db_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      db_cnt        <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= state_nxt;
      db_cnt        <= db_cnt_nxt;
      btn_level     <= (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      if (press_evt) begin
        press_count <= press_count + PRESS_COUNT_W'(1);
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = cnt_width(RPT_MAX);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_armed;
  logic             rpt_stay;
  logic             rpt_entry;
  logic             rpt_hit;

  // rpt_armed separates the initial delay from the steady repeat period.
  always_comb begin
    rpt_stay  = (state == PRESSED) && sync_level;
    rpt_entry = (state_nxt == PRESSED) && (state != PRESSED);
    rpt_hit   = 1'b0;
    if (rpt_stay) begin
      rpt_hit = rpt_armed ? (rpt_cnt == RPT_W'(REPEAT_PERIOD - 1))
                          : (rpt_cnt == RPT_W'(REPEAT_DELAY - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt      <= '0;
      rpt_armed    <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= rpt_hit;
      if (rpt_entry) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b0;
      end else if (rpt_hit) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b1;
      end else if (rpt_stay) begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed table, corner sequences and random stimulus vs a run-length model.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       btn_in = 1'b0;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       repeat_pulse;
  logic [7:0] press_count;

  int checks = 0;
  int passes = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endfunction

  // Reference: a level flips after D+1 consecutive synchronized samples disagreeing with it.
  logic       m_h1 = 1'b0, m_h2 = 1'b0, m_level = 1'b0;
  int         m_run = 0, m_k = 0, edge_no = 0;
  logic [7:0] m_cnt = 8'h00;
  logic       e_press = 1'b0, e_rel = 1'b0, e_rep = 1'b0;

  always @(posedge clk) begin
    logic s;
    edge_no++;
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_rep   = 1'b0;
    if (rst) begin
      m_h1 = 1'b0; m_h2 = 1'b0; m_level = 1'b0;
      m_run = 0; m_k = 0; m_cnt = 8'h00;
    end else begin
      s    = m_h2;
      m_h2 = m_h1;
      m_h1 = btn_in;
      if (s == m_level) begin
        if (m_level) begin
          if (m_run == 0) begin
            m_k++;
            if (REP_EN && (m_k == RD || (m_k > RD && (m_k - RD) % RP == 0))) e_rep = 1'b1;
          end else begin
            m_k = 0;
          end
        end
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = ~m_level;
          m_run   = 0;
          if (m_level) begin
            e_press = 1'b1;
            m_cnt++;
            m_k = 0;
          end else begin
            e_rel = 1'b1;
          end
        end
      end
    end
  end

  int n_press = 0, n_rel = 0, n_rep = 0;

  always @(negedge clk) begin
    if (edge_no > 0) begin
      check("btn_level", btn_level, m_level);
      check("press_pulse", press_pulse, e_press);
      check("release_pulse", release_pulse, e_rel);
      check("repeat_pulse", repeat_pulse, e_rep);
      check("press_count", press_count, m_cnt);
      check("pulses_exclusive",
            ((int'(press_pulse) + int'(release_pulse) + int'(repeat_pulse)) <= 1) ? 1 : 0, 1);
      n_press += int'(press_pulse);
      n_rel   += int'(release_pulse);
      n_rep   += int'(repeat_pulse);
    end
  end

  task automatic cyc(input logic b, input logic r);
    btn_in = b;
    rst    = r;
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       b;
    int         n;
    logic       lvl;
    logic [7:0] cnt;
    int         dp;
    int         dr;
  } seg_t;

  seg_t tbl[12];
  int   p0, r0, q0, len;
  logic b, r, found, exp_rep;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 3,  1'b0, 8'd0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 3,  1'b0, 8'd0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 6,  1'b0, 8'd0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 10, 1'b1, 8'd1, 1, 0};
    tbl[4]  = '{1'b0, 1'b0, 2,  1'b1, 8'd1, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 6,  1'b1, 8'd1, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 10, 1'b0, 8'd1, 0, 1};
    tbl[7]  = '{1'b0, 1'b1, 10, 1'b1, 8'd2, 1, 0};
    tbl[8]  = '{1'b1, 1'b1, 2,  1'b0, 8'd0, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 6,  1'b0, 8'd0, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 1,  1'b1, 8'd1, 1, 0};
    tbl[11] = '{1'b0, 1'b0, 10, 1'b0, 8'd1, 0, 1};

    for (int i = 0; i < 12; i++) begin
      p0 = n_press;
      r0 = n_rel;
      repeat (tbl[i].n) cyc(tbl[i].b, tbl[i].r);
      check($sformatf("seg%0d_level", i), btn_level, tbl[i].lvl);
      check($sformatf("seg%0d_count", i), press_count, tbl[i].cnt);
      check($sformatf("seg%0d_presses", i), n_press - p0, tbl[i].dp);
      check($sformatf("seg%0d_releases", i), n_rel - r0, tbl[i].dr);
    end

    // 256 clean presses wrap the count back to zero.
    repeat (2) cyc(1'b0, 1'b1);
    p0 = n_press;
    for (int i = 0; i < 256; i++) begin
      repeat (8) cyc(1'b1, 1'b0);
      repeat (8) cyc(1'b0, 1'b0);
    end
    check("wrap_count", press_count, 0);
    check("wrap_presses", n_press - p0, 256);

    // Hold after a press and watch for auto-repeat at fixed offsets.
    repeat (2) cyc(1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1'b1, 1'b0);
      if (press_pulse) found = 1'b1;
    end
    check("hold_press_seen", found, 1);
    q0 = n_rep;
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 1'b0);
      exp_rep = REP_EN && i >= RD && ((i - RD) % RP == 0);
      check($sformatf("repeat_t+%0d", i), repeat_pulse, exp_rep);
    end
    check("repeat_total", n_rep - q0, REP_EN ? 4 : 0);

    // Random bursts, occasional resets.
    repeat (2) cyc(1'b0, 1'b1);
    for (int s = 0; s < 300; s++) begin
      b   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 30));
      r   = ($urandom_range(0, 39) == 0);
      repeat (len) cyc(b, r);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
